// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_DMEM, OWN_IMEM} owner_e;
   typedef enum logic {ST_NORMAL, ST_LOCKED} state_e;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned MASK_WIDTH     = DATA_WIDTH_DEF / 8;
   localparam int unsigned STARVE_CNT_W   = 4;

   // Bit positions inside the one-hot grant vector.
   localparam int unsigned GNT_DBG  = 0;
   localparam int unsigned GNT_DMEM = 1;
   localparam int unsigned GNT_IMEM = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: dbg first, then dmem/imem unless locked.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       dbg_req,
   input  logic       dmem_req,
   input  logic       imem_req,
   input  state_e     state,
   input  logic       starve,
   output logic [2:0] gnt_c
);

   // A starved imem outranks dmem; dbg always wins.
   always_comb begin
      gnt_c = '0;
      if (dbg_req) begin
         gnt_c[GNT_DBG] = 1'b1;
      end else if (state == ST_NORMAL) begin
         if (imem_req && (starve || !dmem_req)) begin
            gnt_c[GNT_IMEM] = 1'b1;
         end else if (dmem_req) begin
            gnt_c[GNT_DMEM] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dbg, dmem and imem onto one 1-cycle-latency SRAM port and
// routes each response back to the requester granted the previous cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dbg_lock,
   input  logic                      dbg_req,
   input  logic                      dmem_req,
   input  logic                      imem_req,
   input  logic [ADDR_WIDTH-1:0]     dbg_addr,
   input  logic [ADDR_WIDTH-1:0]     dmem_addr,
   input  logic [ADDR_WIDTH-1:0]     imem_addr,
   input  logic                      dbg_we,
   input  logic                      dmem_we,
   input  logic [DATA_WIDTH-1:0]     dbg_wdata,
   input  logic [DATA_WIDTH-1:0]     dmem_wdata,
   input  logic [DATA_WIDTH/8-1:0]   dbg_wmask,
   input  logic [DATA_WIDTH/8-1:0]   dmem_wmask,
   output logic                      dbg_gnt,
   output logic                      dmem_gnt,
   output logic                      imem_gnt,
   output logic                      dbg_rvalid,
   output logic                      dmem_rvalid,
   output logic                      imem_rvalid,
   output logic [DATA_WIDTH-1:0]     dbg_rdata,
   output logic [DATA_WIDTH-1:0]     dmem_rdata,
   output logic [DATA_WIDTH-1:0]     imem_rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wmask,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam int unsigned CW = STARVE_CNT_W;

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            rd_q;
   logic [CW-1:0]   starve_q, starve_d;
   logic            starve_c;
   logic [2:0]      pick_gnt_c;
   logic [2:0]      gnt_c;

   assign starve_c = (starve_q == CW'(STARVE_LIMIT));

   mem_arb_pick u_pick (
      .dbg_req  (dbg_req),
      .dmem_req (dmem_req),
      .imem_req (imem_req),
      .state    (state_q),
      .starve   (starve_c),
      .gnt_c    (pick_gnt_c)
   );

   // Grants are suppressed combinationally while reset is held.
   assign gnt_c    = rst ? pick_gnt_c : 3'b000;
   assign dbg_gnt  = gnt_c[GNT_DBG];
   assign dmem_gnt = gnt_c[GNT_DMEM];
   assign imem_gnt = gnt_c[GNT_IMEM];

   // Memory port mux and owner of the access issued this cycle.
   always_comb begin
      mem_en    = |gnt_c;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      owner_d   = OWN_NONE;
      if (gnt_c[GNT_DBG]) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_wmask = dbg_wmask;
         owner_d   = OWN_DBG;
      end else if (gnt_c[GNT_DMEM]) begin
         mem_we    = dmem_we;
         mem_addr  = dmem_addr;
         mem_wdata = dmem_wdata;
         mem_wmask = dmem_wmask;
         owner_d   = OWN_DMEM;
      end else if (gnt_c[GNT_IMEM]) begin
         mem_addr  = imem_addr;
         owner_d   = OWN_IMEM;
      end
   end

   // Lock FSM next state and starvation counter update.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         ST_NORMAL: begin
            if (dbg_lock) state_d = ST_LOCKED;
            if (imem_req && !gnt_c[GNT_IMEM]) begin
               if (!starve_c) starve_d = starve_q + CW'(1);
            end else begin
               starve_d = '0;
            end
         end
         ST_LOCKED: begin
            if (!dbg_lock) state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_NORMAL;
         owner_q     <= OWN_NONE;
         rd_q        <= 1'b0;
         starve_q    <= '0;
         dbg_rvalid  <= 1'b0;
         dmem_rvalid <= 1'b0;
         imem_rvalid <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rd_q        <= mem_en && !mem_we;
         starve_q    <= starve_d;
         dbg_rvalid  <= gnt_c[GNT_DBG];
         dmem_rvalid <= gnt_c[GNT_DMEM];
         imem_rvalid <= gnt_c[GNT_IMEM];
      end
   end

   // Read data is steered only to the owner of a completed read.
   assign dbg_rdata  = (owner_q == OWN_DBG  && rd_q) ? mem_rdata : '0;
   assign dmem_rdata = (owner_q == OWN_DMEM && rd_q) ? mem_rdata : '0;
   assign imem_rdata = (owner_q == OWN_IMEM && rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a behavioural model
// with a simple SRAM model on the memory side.
module tb_mem_arbiter;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MW  = DW / 8;
   localparam int          LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic dbg_lock, dbg_req, dmem_req, imem_req;
   logic [AW-1:0] dbg_addr, dmem_addr, imem_addr;
   logic dbg_we, dmem_we;
   logic [DW-1:0] dbg_wdata, dmem_wdata;
   logic [MW-1:0] dbg_wmask, dmem_wmask;
   logic dbg_gnt, dmem_gnt, imem_gnt;
   logic dbg_rvalid, dmem_rvalid, imem_rvalid;
   logic [DW-1:0] dbg_rdata, dmem_rdata, imem_rdata;
   logic mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic [DW-1:0] mem_rdata = '0;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .dbg_lock(dbg_lock),
      .dbg_req(dbg_req), .dmem_req(dmem_req), .imem_req(imem_req),
      .dbg_addr(dbg_addr), .dmem_addr(dmem_addr), .imem_addr(imem_addr),
      .dbg_we(dbg_we), .dmem_we(dmem_we),
      .dbg_wdata(dbg_wdata), .dmem_wdata(dmem_wdata),
      .dbg_wmask(dbg_wmask), .dmem_wmask(dmem_wmask),
      .dbg_gnt(dbg_gnt), .dmem_gnt(dmem_gnt), .imem_gnt(imem_gnt),
      .dbg_rvalid(dbg_rvalid), .dmem_rvalid(dmem_rvalid), .imem_rvalid(imem_rvalid),
      .dbg_rdata(dbg_rdata), .dmem_rdata(dmem_rdata), .imem_rdata(imem_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(int i);
      return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // SRAM model: 256 words, unwritten words read as init_val(index).
   logic [DW-1:0] mem_arr [256];
   logic          mem_wr  [256];
   logic          mem_clear = 1'b1;
   always @(posedge clk) begin : sram
      logic [DW-1:0] cur;
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem_wr[i] <= 1'b0;
      end else if (mem_en) begin
         cur = mem_wr[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : init_val(int'(mem_addr[9:2]));
         if (mem_we) begin
            for (int b = 0; b < MW; b++) if (mem_wmask[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr[9:2]] <= cur;
            mem_wr[mem_addr[9:2]]  <= 1'b1;
         end else begin
            mem_rdata <= cur;
         end
      end
   end

   // Reference model state: 0 none, 1 dbg, 2 dmem, 3 imem.
   logic [DW-1:0] shadow [256];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic          m_locked = 1'b0;
   int            m_starve = 0;
   int            p_own = 0;
   logic          p_we = 1'b0;
   logic [DW-1:0] p_data = '0;
   int            last_win = 0;
   logic          obs_dmem_rvalid, obs_imem_rvalid;
   logic [DW-1:0] obs_dmem_rdata, obs_imem_rdata;

   function automatic int model_win();
      if (!rst) return 0;
      if (dbg_req) return 1;
      if (m_locked) return 0;
      if (imem_req && (m_starve == LIM || !dmem_req)) return 3;
      if (dmem_req) return 2;
      if (imem_req) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0;
      m_starve = 0;
      p_own    = 0;
      p_we     = 1'b0;
   endtask

   // One clock: check grant/memory side and responses, then advance model.
   task automatic cycle();
      int w;
      logic [2:0] eg, ev;
      logic [AW-1:0] ea;
      logic ewe;
      logic [MW-1:0] em;
      logic [DW-1:0] ed;
      logic [3*DW-1:0] er;
      logic [7:0] idx;
      @(negedge clk);
      cyc++;
      if (!rst) model_reset();
      w = model_win();
      eg = 3'b000; ea = '0; ewe = 1'b0; em = '0; ed = '0;
      case (w)
         1: begin eg = 3'b100; ea = dbg_addr;  ewe = dbg_we;  em = dbg_wmask;  ed = dbg_wdata;  end
         2: begin eg = 3'b010; ea = dmem_addr; ewe = dmem_we; em = dmem_wmask; ed = dmem_wdata; end
         3: begin eg = 3'b001; ea = imem_addr; end
         default: ;
      endcase
      checks++;
      if ({dbg_gnt, dmem_gnt, imem_gnt} !== eg) begin
         errors++; $display("FAIL gnt cyc %0d got %b want %b", cyc, {dbg_gnt, dmem_gnt, imem_gnt}, eg);
      end
      checks++;
      if (mem_en !== (w != 0)) begin
         errors++; $display("FAIL mem_en cyc %0d got %b want %b", cyc, mem_en, (w != 0));
      end
      if (w != 0) begin
         checks++;
         if ({mem_addr, mem_we, mem_wmask} !== {ea, ewe, em}) begin
            errors++; $display("FAIL mem_ctl cyc %0d got %h/%b/%h want %h/%b/%h",
                               cyc, mem_addr, mem_we, mem_wmask, ea, ewe, em);
         end
         if (ewe) begin
            checks++;
            if (mem_wdata !== ed) begin
               errors++; $display("FAIL mem_wdata cyc %0d got %h want %h", cyc, mem_wdata, ed);
            end
         end
      end
      ev = {1'(p_own == 1), 1'(p_own == 2), 1'(p_own == 3)};
      er = '0;
      if (!p_we) begin
         if (p_own == 1) er[3*DW-1 -: DW] = p_data;
         if (p_own == 2) er[2*DW-1 -: DW] = p_data;
         if (p_own == 3) er[DW-1:0]       = p_data;
      end
      checks++;
      if ({dbg_rvalid, dmem_rvalid, imem_rvalid} !== ev) begin
         errors++; $display("FAIL rvalid cyc %0d got %b want %b", cyc, {dbg_rvalid, dmem_rvalid, imem_rvalid}, ev);
      end
      checks++;
      if ({dbg_rdata, dmem_rdata, imem_rdata} !== er) begin
         errors++; $display("FAIL rdata cyc %0d got %h want %h", cyc, {dbg_rdata, dmem_rdata, imem_rdata}, er);
      end
      obs_dmem_rvalid = dmem_rvalid; obs_dmem_rdata = dmem_rdata;
      obs_imem_rvalid = imem_rvalid; obs_imem_rdata = imem_rdata;
      last_win = w;
      if (!rst) begin
         model_reset();
      end else begin
         idx    = ea[9:2];
         p_own  = w;
         p_we   = ewe;
         p_data = shadow[idx];
         if (w != 0 && ewe)
            for (int b = 0; b < MW; b++) if (em[b]) shadow[idx][8*b +: 8] = ed[8*b +: 8];
         if (!m_locked) m_starve = (imem_req && w != 3) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
         m_locked = dbg_lock;
      end
      @(posedge clk); #1;
   endtask

   task automatic expect_win(int want, string name);
      checks++;
      if (last_win !== want) begin
         errors++; $display("FAIL %s winner got %0d want %0d", name, last_win, want);
      end
   endtask

   task automatic idle();
      dbg_req = 0; dmem_req = 0; imem_req = 0; dbg_lock = 0; dbg_we = 0; dmem_we = 0;
      cycle();
   endtask

   task automatic test_reset();
      dbg_req = 1; dmem_req = 1; imem_req = 1; dbg_lock = 0;
      cycle(); cycle();
      rst = 1'b1;
      idle();
   endtask

   task automatic test_single_read();
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF; dbg_wmask = 4'hF;
      cycle(); expect_win(1, "preload");
      dbg_req = 0; dbg_we = 0; imem_req = 1; imem_addr = 32'h10;
      cycle(); expect_win(3, "single_read");
      imem_req = 0;
      cycle();
      checks++;
      if (obs_imem_rvalid !== 1'b1 || obs_imem_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL single_read resp got %b/%h want 1/deadbeef", obs_imem_rvalid, obs_imem_rdata);
      end
   endtask

   task automatic test_contention();
      idle();
      dmem_req = 1; dmem_we = 1; dmem_addr = 32'h20; dmem_wdata = 32'h1234; dmem_wmask = 4'hF;
      imem_req = 1; imem_addr = 32'h0;
      cycle(); expect_win(2, "contention_dmem");
      dmem_req = 0; dmem_we = 0;
      cycle(); expect_win(3, "contention_imem");
      checks++;
      if (obs_dmem_rvalid !== 1'b1 || obs_dmem_rdata !== '0) begin
         errors++; $display("FAIL contention dmem resp got %b/%h want 1/0", obs_dmem_rvalid, obs_dmem_rdata);
      end
      imem_req = 0;
      cycle();
      checks++;
      if (obs_imem_rvalid !== 1'b1 || obs_dmem_rvalid !== 1'b0) begin
         errors++; $display("FAIL contention imem resp got %b/%b want 1/0", obs_imem_rvalid, obs_dmem_rvalid);
      end
   endtask

   task automatic test_starvation();
      int exp_w [6];
      exp_w = '{2, 2, 2, 2, 3, 2};
      idle();
      dmem_req = 1; dmem_we = 0; dmem_addr = 32'h30; imem_req = 1; imem_addr = 32'h4;
      for (int i = 0; i < 6; i++) begin
         cycle(); expect_win(exp_w[i], "starvation");
      end
   endtask

   task automatic test_lock();
      idle();
      dbg_lock = 1; dmem_req = 1; imem_req = 1; imem_addr = 32'h40;
      cycle(); expect_win(2, "lock_same_cycle");
      dmem_req = 0;
      cycle(); expect_win(0, "locked_imem");
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hCAFE_F00D; dbg_wmask = 4'hF;
      cycle(); expect_win(1, "locked_dbg");
      dbg_req = 0; dbg_we = 0; dbg_lock = 0;
      cycle(); expect_win(0, "unlock_delay");
      cycle(); expect_win(3, "unlocked_imem");
      imem_req = 0;
      cycle();
      checks++;
      if (obs_imem_rvalid !== 1'b1 || obs_imem_rdata !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL lock readback got %b/%h want 1/cafef00d", obs_imem_rvalid, obs_imem_rdata);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      dmem_req = 1; dmem_we = 0; dmem_addr = 32'h20;
      @(negedge clk);
      checks++;
      if (dmem_gnt !== 1'b1) begin
         errors++; $display("FAIL reset_mid grant got %b want 1", dmem_gnt);
      end
      rst = 1'b0; #1;
      checks++;
      if ({dbg_gnt, dmem_gnt, imem_gnt, mem_en} !== 4'b0000) begin
         errors++; $display("FAIL reset_mid gnt got %b want 0000", {dbg_gnt, dmem_gnt, imem_gnt, mem_en});
      end
      model_reset();
      @(posedge clk); #1;
      checks++;
      if (dmem_rvalid !== 1'b0) begin
         errors++; $display("FAIL reset_mid rvalid got %b want 0", dmem_rvalid);
      end
      cycle();
      rst = 1'b1;
      cycle(); expect_win(2, "reset_mid_regrant");
      dmem_req = 0;
      cycle();
      checks++;
      if (obs_dmem_rvalid !== 1'b1 || obs_dmem_rdata !== 32'h0000_1234) begin
         errors++; $display("FAIL reset_mid readback got %b/%h want 1/00001234", obs_dmem_rvalid, obs_dmem_rdata);
      end
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(49) != 0);
         if ($urandom_range(15) == 0) dbg_lock = ~dbg_lock;
         dbg_req    = ($urandom_range(3) == 0);
         dmem_req   = ($urandom_range(1) == 0);
         imem_req   = ($urandom_range(1) == 0);
         dbg_we     = 1'($urandom_range(1));
         dmem_we    = 1'($urandom_range(1));
         dbg_addr   = {22'b0, 8'($urandom), 2'b00};
         dmem_addr  = {22'b0, 8'($urandom), 2'b00};
         imem_addr  = {22'b0, 8'($urandom), 2'b00};
         dbg_wdata  = $urandom;
         dmem_wdata = $urandom;
         dbg_wmask  = 4'($urandom);
         dmem_wmask = 4'($urandom);
         cycle();
      end
      rst = 1'b1;
      idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      dbg_lock = 0; dbg_req = 0; dmem_req = 0; imem_req = 0;
      dbg_addr = '0; dmem_addr = '0; imem_addr = '0;
      dbg_we = 0; dmem_we = 0; dbg_wdata = '0; dmem_wdata = '0; dbg_wmask = '0; dmem_wmask = '0;
      @(posedge clk); #1;
      mem_clear = 1'b0;
      test_reset();
      test_single_read();
      test_contention();
      test_starvation();
      test_lock();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
